// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory port arbiter: FSM states, grant owner, wait-counter width.
// Also holds the IDLE-state arbitration rule so the priority policy lives in one place.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_CPU  = 2'd1,
        GNT_EXT  = 2'd2
    } gnt_t;

    // Wide enough for MEM_LAT-1 with MEM_LAT up to 7.
    localparam int CNT_W = 3;

    // cpu_elig already folds in ext_hold; CPU wins a tie.
    function automatic gnt_t arb_idle(input logic cpu_elig, input logic ext_req);
        gnt_t g;
        g = GNT_NONE;
        if (cpu_elig) begin
            g = GNT_CPU;
        end else if (ext_req) begin
            g = GNT_EXT;
        end
        return g;
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Two-requester single-port memory arbiter: write acks 2 cycles after request, reads 2+MEM_LAT.
// Requesters hold req until their one-cycle ack; cpu_stall freezes the CPU FSM meanwhile.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_stall,
    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              ext_ack,
    input  logic              ext_hold,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

    state_t            state_q, state_d;
    gnt_t              gnt_q, gnt_d;
    gnt_t              nxt_gnt;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              ext_ack_q, ext_ack_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] ext_rdata_q, ext_rdata_d;
    logic              cpu_elig;

    assign cpu_elig = cpu_req & ~ext_hold;

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        cnt_d       = cnt_q;
        nxt_gnt     = GNT_NONE;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_ack_d   = 1'b0;
        ext_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        ext_rdata_d = ext_rdata_q;

        case (state_q)
            ST_IDLE: begin
                nxt_gnt = arb_idle(cpu_elig, ext_req);
            end
            ST_ACCESS: begin
                // mem_we_q still carries the latched request direction here.
                if (mem_we_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    if (gnt_q == GNT_CPU) begin
                        cpu_rdata_d = mem_rdata;
                    end else begin
                        ext_rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                // The requester just acked still shows req this cycle; only the other side may chain.
                if (gnt_q == GNT_CPU && ext_req) begin
                    nxt_gnt = GNT_EXT;
                end else if (gnt_q == GNT_EXT && cpu_elig) begin
                    nxt_gnt = GNT_CPU;
                end else begin
                    state_d = ST_IDLE;
                    gnt_d   = GNT_NONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = GNT_NONE;
            end
        endcase

        if (nxt_gnt != GNT_NONE) begin
            state_d  = ST_ACCESS;
            gnt_d    = nxt_gnt;
            mem_en_d = 1'b1;
            if (nxt_gnt == GNT_CPU) begin
                mem_we_d    = cpu_we;
                mem_addr_d  = cpu_addr;
                mem_wdata_d = cpu_wdata;
            end else begin
                mem_we_d    = ext_we;
                mem_addr_d  = ext_addr;
                mem_wdata_d = ext_wdata;
            end
        end

        if (state_d == ST_DONE) begin
            cpu_ack_d = (gnt_q == GNT_CPU);
            ext_ack_d = (gnt_q == GNT_EXT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            gnt_q       <= GNT_NONE;
            cnt_q       <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            ext_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            ext_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            cnt_q       <= cnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_ack_q   <= cpu_ack_d;
            ext_ack_q   <= ext_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            ext_rdata_q <= ext_rdata_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign ext_ack   = ext_ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign ext_rdata = ext_rdata_q;
    assign cpu_stall = cpu_req & ~cpu_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (MEM_LAT 1, 2, 7), each with its own memory model.
// Directed stimulus pushes expected memory accesses and acks; a monitor pops and compares them.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        cpu_req   [3];
    logic        cpu_we    [3];
    logic [15:0] cpu_addr  [3];
    logic [15:0] cpu_wdata [3];
    logic [15:0] cpu_rdata [3];
    logic        cpu_ack   [3];
    logic        cpu_stall [3];
    logic        ext_req   [3];
    logic        ext_we    [3];
    logic [15:0] ext_addr  [3];
    logic [15:0] ext_wdata [3];
    logic [15:0] ext_rdata [3];
    logic        ext_ack   [3];
    logic        ext_hold  [3];
    logic        mem_en    [3];
    logic        mem_we    [3];
    logic [15:0] mem_addr  [3];
    logic [15:0] mem_wdata [3];

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    typedef struct {
        int          cyc;
        int          inst;
        bit          ext;
        bit          we;
        bit          chkd;
        logic [15:0] addr;
        logic [15:0] dat;
    } ev_t;

    ev_t acc_q[$];
    ev_t ack_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : (g == 1) ? 2 : 7;
        logic [15:0] mem_rdata;
        logic [15:0] mem [0:1023];
        logic        pv  [0:7];
        logic [9:0]  pa  [0:7];

        mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .cpu_req   (cpu_req[g]),
            .cpu_we    (cpu_we[g]),
            .cpu_addr  (cpu_addr[g]),
            .cpu_wdata (cpu_wdata[g]),
            .cpu_rdata (cpu_rdata[g]),
            .cpu_ack   (cpu_ack[g]),
            .cpu_stall (cpu_stall[g]),
            .ext_req   (ext_req[g]),
            .ext_we    (ext_we[g]),
            .ext_addr  (ext_addr[g]),
            .ext_wdata (ext_wdata[g]),
            .ext_rdata (ext_rdata[g]),
            .ext_ack   (ext_ack[g]),
            .ext_hold  (ext_hold[g]),
            .mem_en    (mem_en[g]),
            .mem_we    (mem_we[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_rdata (mem_rdata)
        );

        // Read data is only valid exactly LAT cycles after the strobe; 0xDEAD otherwise.
        assign mem_rdata = pv[LAT-1] ? mem[pa[LAT-1]] : 16'hDEAD;

        initial begin
            for (int k = 0; k < 1024; k++) mem[k] = 16'(k) ^ 16'hA5A5;
            mem[16] = 16'hBEEF;
            for (int k = 0; k < 8; k++) begin
                pv[k] = 1'b0;
                pa[k] = '0;
            end
            forever begin
                @(posedge clk);
                if (mem_en[g] && mem_we[g]) mem[mem_addr[g][9:0]] <= mem_wdata[g];
                for (int k = 7; k > 0; k--) begin
                    pv[k] <= pv[k-1];
                    pa[k] <= pa[k-1];
                end
                pv[0] <= mem_en[g] && !mem_we[g];
                pa[0] <= mem_addr[g][9:0];
            end
        end
    end

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic exp_acc(input int c, input int i, input bit we, input logic [15:0] a,
                           input logic [15:0] d);
        ev_t e;
        e.cyc = c; e.inst = i; e.ext = 1'b0; e.we = we; e.chkd = we; e.addr = a; e.dat = d;
        acc_q.push_back(e);
    endtask

    task automatic exp_ack(input int c, input int i, input bit ext, input bit chkd,
                           input logic [15:0] d);
        ev_t e;
        e.cyc = c; e.inst = i; e.ext = ext; e.we = 1'b0; e.chkd = chkd; e.addr = '0; e.dat = d;
        ack_q.push_back(e);
    endtask

    task automatic check_acc(input int i);
        ev_t e;
        if (acc_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL acc_unexpected: inst %0d addr %0h at cycle %0d, none required",
                     i, mem_addr[i], cyc);
        end else begin
            e = acc_q.pop_front();
            chk("acc_cycle", cyc, e.cyc);
            chk("acc_inst", i, e.inst);
            chk("acc_addr", mem_addr[i], e.addr);
            chk("acc_we", mem_we[i], e.we);
            if (e.chkd) chk("acc_wdata", mem_wdata[i], e.dat);
        end
    endtask

    task automatic check_ack(input int i, input bit ext, input logic [15:0] rd);
        ev_t e;
        if (ack_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL ack_unexpected: inst %0d ext %0d at cycle %0d, none required",
                     i, ext, cyc);
        end else begin
            e = ack_q.pop_front();
            chk("ack_cycle", cyc, e.cyc);
            chk("ack_inst", i, e.inst);
            chk("ack_port", ext, e.ext);
            if (e.chkd) chk("ack_rdata", rd, e.dat);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (mem_en[i]) check_acc(i);
            if (cpu_ack[i]) check_ack(i, 1'b0, cpu_rdata[i]);
            if (ext_ack[i]) check_ack(i, 1'b1, ext_rdata[i]);
        end
    end

    // Requester model: hold req until ack, drop it on the following edge.
    task automatic issue(input int i, input bit ext, input bit we, input logic [15:0] a,
                         input logic [15:0] d);
        int n;
        n = 0;
        if (ext) begin
            ext_we[i] = we; ext_addr[i] = a; ext_wdata[i] = d; ext_req[i] = 1'b1;
        end else begin
            cpu_we[i] = we; cpu_addr[i] = a; cpu_wdata[i] = d; cpu_req[i] = 1'b1;
        end
        while (n < 200) begin
            @(negedge clk);
            if (ext ? ext_ack[i] : cpu_ack[i]) break;
            n++;
        end
        if (n >= 200) begin
            n_tests++;
            n_fail++;
            $display("FAIL ack_timeout: inst %0d ext %0d addr %0h, no ack within 200 cycles",
                     i, ext, a);
        end
        @(posedge clk);
        #1;
        if (ext) ext_req[i] = 1'b0;
        else cpu_req[i] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        logic [15:0] ext_exp [3];
        ext_exp[0] = 16'hA5E5;
        ext_exp[1] = 16'hA5E4;
        ext_exp[2] = 16'hA5E7;
        for (int i = 0; i < 3; i++) begin
            cpu_req[i] = 0; cpu_we[i] = 0; cpu_addr[i] = 0; cpu_wdata[i] = 0;
            ext_req[i] = 0; ext_we[i] = 0; ext_addr[i] = 0; ext_wdata[i] = 0;
            ext_hold[i] = 0;
        end
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("reset_outputs", {mem_en[i], mem_we[i], mem_addr[i], mem_wdata[i], cpu_ack[i],
                                  ext_ack[i], cpu_rdata[i], ext_rdata[i], cpu_stall[i]}, 96'd0);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // CPU read, MEM_LAT=1, stall across request/access/wait cycles.
        t0 = cyc;
        exp_acc(t0 + 1, 0, 1'b0, 16'h0010, 16'h0);
        exp_ack(t0 + 3, 0, 1'b0, 1'b1, 16'hBEEF);
        fork
            issue(0, 1'b0, 1'b0, 16'h0010, 16'h0);
            begin
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    chk("cpu_stall_read", cpu_stall[0], (k < 3) ? 1'b1 : 1'b0);
                end
            end
        join

        // Ext write then CPU read-back; bus idles with last address/data held.
        t0 = cyc;
        exp_acc(t0 + 1, 0, 1'b1, 16'h0100, 16'h1234);
        exp_ack(t0 + 2, 0, 1'b1, 1'b0, 16'h0);
        issue(0, 1'b1, 1'b1, 16'h0100, 16'h1234);
        chk("idle_bus_hold", {mem_en[0], mem_we[0], mem_addr[0], mem_wdata[0]},
            {1'b0, 1'b0, 16'h0100, 16'h1234});
        t0 = cyc;
        exp_acc(t0 + 1, 0, 1'b0, 16'h0100, 16'h0);
        exp_ack(t0 + 3, 0, 1'b0, 1'b1, 16'h1234);
        issue(0, 1'b0, 1'b0, 16'h0100, 16'h0);

        // Request dropped before ack: access still completes.
        t0 = cyc;
        exp_acc(t0 + 1, 0, 1'b0, 16'h0020, 16'h0);
        exp_ack(t0 + 3, 0, 1'b0, 1'b1, 16'hA585);
        cpu_we[0] = 1'b0; cpu_addr[0] = 16'h0020; cpu_req[0] = 1'b1;
        @(posedge clk); #1 cpu_req[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Contention, MEM_LAT=2: CPU first, ext chained from DONE with no IDLE bubble.
        t0 = cyc;
        exp_acc(t0 + 1, 1, 1'b0, 16'h0010, 16'h0);
        exp_ack(t0 + 4, 1, 1'b0, 1'b1, 16'hBEEF);
        exp_acc(t0 + 5, 1, 1'b0, 16'h0020, 16'h0);
        exp_ack(t0 + 8, 1, 1'b1, 1'b1, 16'hA585);
        fork
            issue(1, 1'b0, 1'b0, 16'h0010, 16'h0);
            issue(1, 1'b1, 1'b0, 16'h0020, 16'h0);
        join

        // ext_hold: only ext served while CPU waits; CPU granted once hold drops.
        ext_hold[1] = 1'b1;
        t0 = cyc;
        for (int j = 0; j < 3; j++) begin
            exp_acc(t0 + 5 * j + 1, 1, 1'b0, 16'h0040 + 16'(j), 16'h0);
            exp_ack(t0 + 5 * j + 4, 1, 1'b1, 1'b1, ext_exp[j]);
        end
        exp_acc(t0 + 16, 1, 1'b0, 16'h0030, 16'h0);
        exp_ack(t0 + 19, 1, 1'b0, 1'b1, 16'hA595);
        fork
            issue(1, 1'b0, 1'b0, 16'h0030, 16'h0);
            begin
                for (int j = 0; j < 3; j++) issue(1, 1'b1, 1'b0, 16'h0040 + 16'(j), 16'h0);
                ext_hold[1] = 1'b0;
                @(negedge clk);
                chk("cpu_stall_under_hold", cpu_stall[1], 1'b1);
            end
        join

        // Reset during WAIT abandons the read; it restarts from IDLE afterwards.
        t0 = cyc;
        exp_acc(t0 + 1, 1, 1'b0, 16'h0010, 16'h0);
        exp_acc(t0 + 4, 1, 1'b0, 16'h0010, 16'h0);
        exp_ack(t0 + 7, 1, 1'b0, 1'b1, 16'hBEEF);
        fork
            issue(1, 1'b0, 1'b0, 16'h0010, 16'h0);
            begin
                @(posedge clk);
                @(posedge clk);
                #1 rst_n = 1'b0;
                #1;
                chk("async_reset", {mem_en[1], cpu_ack[1], cpu_rdata[1]}, 96'd0);
                @(posedge clk);
                #1 rst_n = 1'b1;
            end
        join

        // MEM_LAT=7: seven WAIT cycles, ack at request + 9.
        t0 = cyc;
        exp_acc(t0 + 1, 2, 1'b0, 16'h0010, 16'h0);
        exp_ack(t0 + 9, 2, 1'b0, 1'b1, 16'hBEEF);
        issue(2, 1'b0, 1'b0, 16'h0010, 16'h0);
        t0 = cyc;
        exp_acc(t0 + 1, 2, 1'b0, 16'h0055, 16'h0);
        exp_ack(t0 + 9, 2, 1'b1, 1'b1, 16'hA5F0);
        issue(2, 1'b1, 1'b0, 16'h0055, 16'h0);

        repeat (3) @(posedge clk);
        #1;
        chk("acc_q_drained", acc_q.size(), 0);
        chk("ack_q_drained", ack_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
